// File: rtl/carfield_addr_rule_table_pkg.sv
// carfield_pkg: rule types, reset contents and config field offsets for the
// runtime-programmable external-AXI address rule table.
package carfield_pkg;

  // Upper bounds the table storage types are sized for.
  localparam int unsigned MaxRules = 16;
  localparam int unsigned RuleIdxW = 4;

  // Config field offsets (low two bits of the config address).
  localparam logic [1:0] CfgFieldStart = 2'd0;
  localparam logic [1:0] CfgFieldEnd   = 2'd1;
  localparam logic [1:0] CfgFieldIdxEn = 2'd2;
  localparam logic [1:0] CfgFieldLock  = 2'd3;

  // Existing external-port region map.
  localparam logic [63:0] L2Port1Base      = 64'h0000_0000_7800_0000;
  localparam logic [63:0] L2Port1End       = 64'h0000_0000_7820_0000;
  localparam logic [63:0] L2Port2Base      = 64'h0000_0000_7820_0000;
  localparam logic [63:0] L2Port2End       = 64'h0000_0000_7840_0000;
  localparam logic [63:0] SafetyIslandBase = 64'h0000_0000_6000_0000;
  localparam logic [63:0] SafetyIslandEnd  = 64'h0000_0000_6080_0000;
  localparam logic [63:0] MailboxBase      = 64'h0000_0000_4000_0000;
  localparam logic [63:0] MailboxEnd       = 64'h0000_0000_4000_1000;
  localparam logic [63:0] IntClusterBase   = 64'h0000_0000_5000_0000;
  localparam logic [63:0] IntClusterEnd    = 64'h0000_0000_5080_0000;

  typedef struct packed {
    logic [63:0]         start_addr;
    logic [63:0]         end_addr;
    logic [RuleIdxW-1:0] idx;
    logic                en;
  } addr_rule_t;

  // Slot 0 is element 0; only the first NumRules entries are used.
  typedef addr_rule_t [MaxRules-1:0] addr_rule_tbl_t;

  function automatic addr_rule_t make_rule(input logic [63:0] s, input logic [63:0] e,
                                           input logic [RuleIdxW-1:0] idx);
    addr_rule_t r;
    r.start_addr = s;
    r.end_addr   = e;
    r.idx        = idx;
    r.en         = 1'b1;
    return r;
  endfunction

  // Slots 0..4 mirror the old fixed map; the remaining slots reset disabled.
  function automatic addr_rule_tbl_t default_rules();
    addr_rule_tbl_t t;
    t    = '0;
    t[0] = make_rule(L2Port1Base, L2Port1End, 4'd0);
    t[1] = make_rule(L2Port2Base, L2Port2End, 4'd1);
    t[2] = make_rule(SafetyIslandBase, SafetyIslandEnd, 4'd2);
    t[3] = make_rule(MailboxBase, MailboxEnd, 4'd3);
    t[4] = make_rule(IntClusterBase, IntClusterEnd, 4'd4);
    return t;
  endfunction

  localparam addr_rule_tbl_t DefaultRules = default_rules();

endpackage

// File: rtl/carfield_addr_rule_table_rule_match.sv
// carfield_rule_match: per-rule range compare plus lowest-index priority encoder.
// The two halves have separate inputs so the hit vector can be registered
// between them.
module carfield_rule_match
  import carfield_pkg::*;
#(
  parameter int unsigned NumRules  = 8,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdxWidth  = 3,
  parameter int unsigned RuleW     = 3
) (
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [NumRules-1:0][AddrWidth-1:0]  start_i,
  input  logic [NumRules-1:0][AddrWidth-1:0]  end_i,
  input  logic [NumRules-1:0]                 en_i,
  output logic [NumRules-1:0]                 hit_o,
  input  logic [NumRules-1:0]                 enc_hit_i,
  input  logic [NumRules-1:0][IdxWidth-1:0]   enc_idx_i,
  output logic                                enc_miss_o,
  output logic [IdxWidth-1:0]                 enc_idx_o,
  output logic [RuleW-1:0]                    enc_rule_o
);

  // Half-open unsigned range compare; end <= start can never satisfy both terms.
  for (genvar gi = 0; gi < NumRules; gi++) begin : g_hit
    assign hit_o[gi] = en_i[gi] && (addr_i >= start_i[gi]) && (addr_i < end_i[gi]);
  end

  // Scan high to low so the lowest matching slot is the last one written.
  always_comb begin
    enc_miss_o = 1'b1;
    enc_idx_o  = '0;
    enc_rule_o = '0;
    for (int r = NumRules - 1; r >= 0; r--) begin
      if (enc_hit_i[r]) begin
        enc_miss_o = 1'b0;
        enc_idx_o  = enc_idx_i[r];
        enc_rule_o = RuleW'(r);
      end
    end
  end

endmodule

// File: rtl/carfield_addr_rule_table.sv
// carfield_addr_rule_table: programmable, lockable address decode table with a
// two-stage valid/ready lookup pipeline and a combinational-read config port.
module carfield_addr_rule_table
  import carfield_pkg::*;
#(
  parameter int unsigned    NumRules  = 8,
  parameter int unsigned    NumSlv    = 5,
  parameter int unsigned    AddrWidth = 48,
  parameter addr_rule_tbl_t RuleInit  = DefaultRules,
  localparam int unsigned   IdxWidth  = (NumSlv > 1) ? $clog2(NumSlv) : 1,
  localparam int unsigned   RuleW     = (NumRules > 1) ? $clog2(NumRules) : 1,
  localparam int unsigned   CfgAddrW  = $clog2(NumRules) + 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic [RuleW-1:0]     rsp_rule_o,
  output logic                 rsp_miss_o,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [CfgAddrW-1:0]  cfg_addr_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  output logic                 locked_o
);

  logic [NumRules-1:0][AddrWidth-1:0] start_q, start_d, end_q, end_d;
  logic [NumRules-1:0][IdxWidth-1:0]  idx_q, idx_d;
  logic [NumRules-1:0]                en_q, en_d;
  logic                               locked_q, locked_d, cfg_err_q, cfg_err_d;

  // Stage 1 keeps the hit vector and an idx snapshot so a later table write
  // cannot alter an entry that was already accepted. The address itself is not
  // needed past the compare.
  logic                               s1_valid_q, s1_valid_d;
  logic [NumRules-1:0]                s1_hit_q, s1_hit_d;
  logic [NumRules-1:0][IdxWidth-1:0]  s1_idx_q, s1_idx_d;
  logic                               rsp_valid_q, rsp_valid_d, rsp_miss_q, rsp_miss_d;
  logic [IdxWidth-1:0]                rsp_idx_q, rsp_idx_d;
  logic [RuleW-1:0]                   rsp_rule_q, rsp_rule_d;

  logic [NumRules-1:0] match_hit, slot_sel;
  logic                enc_miss;
  logic [IdxWidth-1:0] enc_idx;
  logic [RuleW-1:0]    enc_rule;
  logic [1:0]          cfg_field;
  logic [CfgAddrW-1:0] cfg_slot;
  logic [IdxWidth-1:0] wr_idx;
  logic                cfg_wr_ok, s2_free, unused_wdata;

  assign cfg_field    = cfg_addr_i[1:0];
  assign cfg_slot     = cfg_addr_i >> 2;
  assign wr_idx       = cfg_wdata_i[IdxWidth-1:0];
  assign unused_wdata = ^cfg_wdata_i;

  // One-hot slot decode; an all-zero vector means the slot is out of range.
  for (genvar gi = 0; gi < NumRules; gi++) begin : g_slot_sel
    assign slot_sel[gi] = (cfg_slot == CfgAddrW'(gi));
  end

  // Classify the config access; any error blocks the write and zeroes the read.
  always_comb begin
    cfg_err_d = cfg_req_i && ((cfg_we_i && locked_q) ||
                              (cfg_field == CfgFieldLock && cfg_slot != '0) ||
                              !(|slot_sel) ||
                              (cfg_we_i && cfg_field == CfgFieldIdxEn && 32'(wr_idx) >= NumSlv));
    cfg_wr_ok = cfg_req_i && cfg_we_i && !cfg_err_d;
  end

  // Next-state of the rule table and the sticky lock bit.
  always_comb begin
    start_d  = start_q;
    end_d    = end_q;
    idx_d    = idx_q;
    en_d     = en_q;
    locked_d = locked_q;
    if (cfg_wr_ok) begin
      for (int r = 0; r < NumRules; r++) begin
        if (slot_sel[r]) begin
          case (cfg_field)
            CfgFieldStart: start_d[r] = cfg_wdata_i[AddrWidth-1:0];
            CfgFieldEnd:   end_d[r]   = cfg_wdata_i[AddrWidth-1:0];
            CfgFieldIdxEn: begin
              idx_d[r] = wr_idx;
              en_d[r]  = cfg_wdata_i[63];
            end
            default: ;
          endcase
        end
      end
      if (cfg_field == CfgFieldLock && cfg_wdata_i[0]) locked_d = 1'b1;
    end
  end

  // Combinational config read of the addressed field, zero-extended.
  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_req_i && !cfg_err_d) begin
      for (int r = 0; r < NumRules; r++) begin
        if (slot_sel[r]) begin
          case (cfg_field)
            CfgFieldStart: cfg_rdata_o[AddrWidth-1:0] = start_q[r];
            CfgFieldEnd:   cfg_rdata_o[AddrWidth-1:0] = end_q[r];
            CfgFieldIdxEn: begin
              cfg_rdata_o[63]           = en_q[r];
              cfg_rdata_o[IdxWidth-1:0] = idx_q[r];
            end
            default: ;
          endcase
        end
      end
      if (cfg_field == CfgFieldLock) cfg_rdata_o[0] = locked_q;
    end
  end

  carfield_rule_match #(
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth),
    .RuleW     (RuleW)
  ) u_match (
    .addr_i     (req_addr_i),
    .start_i    (start_q),
    .end_i      (end_q),
    .en_i       (en_q),
    .hit_o      (match_hit),
    .enc_hit_i  (s1_hit_q),
    .enc_idx_i  (s1_idx_q),
    .enc_miss_o (enc_miss),
    .enc_idx_o  (enc_idx),
    .enc_rule_o (enc_rule)
  );

  assign s2_free     = !rsp_valid_q || rsp_ready_i;
  assign req_ready_o = !s1_valid_q || s2_free;

  // Two one-entry stages, each advancing when its downstream is empty or draining.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hit_d    = s1_hit_q;
    s1_idx_d    = s1_idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_miss_d  = rsp_miss_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_rule_d  = rsp_rule_q;
    if (req_ready_o) begin
      s1_valid_d = req_valid_i;
      if (req_valid_i) begin
        s1_hit_d = match_hit;
        s1_idx_d = idx_q;
      end
    end
    if (s2_free) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_miss_d = enc_miss;
        rsp_idx_d  = enc_idx;
        rsp_rule_d = enc_rule;
      end
    end
  end

  // State registers; reset reloads the table, unlocks and empties the pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRules; r++) begin
        start_q[r] <= RuleInit[r].start_addr[AddrWidth-1:0];
        end_q[r]   <= RuleInit[r].end_addr[AddrWidth-1:0];
        idx_q[r]   <= RuleInit[r].idx[IdxWidth-1:0];
        en_q[r]    <= RuleInit[r].en;
      end
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      s1_idx_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_miss_q  <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_rule_q  <= '0;
    end else begin
      start_q     <= start_d;
      end_q       <= end_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      locked_q    <= locked_d;
      cfg_err_q   <= cfg_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_idx_q    <= s1_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_miss_q  <= rsp_miss_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_rule_q  <= rsp_rule_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_miss_o  = rsp_miss_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_rule_o  = rsp_rule_q;
  assign cfg_err_o   = cfg_err_q;
  assign locked_o    = locked_q;

endmodule
